td4_prog_loader: RTL and testbench
==================================

// Module: td4_prog_loader
// PURPOSE
//  Instruction memory and byte-stream loader sitting directly upstream of the TD4 cpu.
//  Serves the cpu fetch port (4-bit address in, 8-bit data out).
//  Accepts a framed program over a valid/ready byte stream and writes it into a 16x8 RAM.
//  Holds the cpu in reset while a program is absent or being loaded.
// PARAMETERS
//  HEADER     8'hA5  frame start byte
//  HOLD_CYC   4      extra cycles cpu_reset stays high after a good load (1..15)
// PORTS
//  clock      in   1  system clock; all state updates on posedge
//  reset      in   1  synchronous, active-high reset
//  address    in   4  cpu fetch address (cpu ip)
//  data       out  8  instruction at address (combinational read)
//  ld_valid   in   1  loader byte valid
//  ld_data    in   8  loader byte
//  ld_ready   out  1  loader byte accepted when ld_valid && ld_ready
//  cpu_reset  out  1  drives cpu reset; 1 = cpu held
//  loaded     out  1  1 while a verified program is present and running
//  load_err   out  1  sticky: last frame failed; cleared on next accepted HEADER
// BEHAVIOUR
//  Reset: state=IDLE, len=0, cpu_reset=1, loaded=0, load_err=0, ld_ready=1, data=8'h00.
//  Read: data = (address < len) ? mem[address] : 8'h00 (8'h00 = add a,0, a NOP); same-cycle, no latency.
//  Frame: HEADER, N, N payload bytes, SUM; SUM = payload bytes summed mod 256.
//  FSM (transitions only on accepted bytes, except HOLD):
//   IDLE: cpu_reset=1. HEADER -> LEN, clear load_err. Any other byte dropped.
//   LEN:  N in 1..16 -> DATA, idx=0, acc=0. N=0 or N>16 -> IDLE, load_err=1, len=0.
//   DATA: mem[idx]<=byte, acc+=byte, idx++. After Nth byte -> SUM.
//   SUM:  byte==acc -> HOLD, len<=N, cnt=HOLD_CYC. Else -> IDLE, load_err=1, len=0.
//   HOLD: ld_ready=0, cpu_reset=1, cnt-- each cycle. At cnt==0 -> RUN.
//   RUN:  cpu_reset=0, loaded=1. HEADER -> LEN: cpu_reset=1, loaded=0, len=0 the same edge.
//         Other bytes dropped.
//  ld_ready=1 in every state except HOLD.
//  A HEADER value received in LEN/DATA/SUM is data, not a restart.
//  len is 0 from header acceptance until SUM passes, so the cpu sees NOPs and no partial program.
//  Widths: idx 5-bit (0..16); acc 8-bit wrapping; N compared as 8-bit before truncation.
//  reset mid-frame: back to the reset state immediately; RAM contents retained but len=0 masks them.
//  cpu_reset is registered, no glitches. First cpu fetch after release reads address 0.
// STRUCTURE
//  td4_pkg: state enum (IDLE, LEN, DATA, SUM, HOLD, RUN), HEADER default, DEPTH=16, NOP=8'h00.
//  Sub-module td4_prog_ram: 16x8, 1 sync write port, 1 async read port, no reset.
//  Loader FSM, idx/acc/cnt/len registers and read mask live in td4_prog_loader.
// TESTING
//  Out of reset, no load: cpu_reset=1, loaded=0, data=00 for all 16 addresses.
//  Good load: A5,02,3F,B3,F2.
//   -> cpu_reset falls 4 cycles after SUM accepted; loaded=1.
//   -> data@0=3F, data@1=B3, data@2..15=00.
//  Bad checksum: A5,01,B7,00 -> load_err=1, cpu_reset=1, len=0 (data@0=00); next A5 clears load_err.
//  Bad length: A5,00 and A5,11 -> each gives load_err=1, return to IDLE, no RAM write.
//  Backpressure and stalls: ld_valid gaps mid-frame leave state unchanged.
//   Bytes offered in HOLD are not accepted (ld_ready=0) and are taken after RUN.
//  Reload in RUN: A5 -> cpu_reset=1 next cycle, loaded=0.
//   Full 16-byte frame with SUM wrap past 255 -> new program runs.
//  Reset asserted in DATA after 3 bytes -> IDLE, data=00 everywhere, a following full frame loads correctly.

Source files
------------

// File: rtl/td4_prog_loader_pkg.sv
// Shared types and constants for the TD4 program loader and its RAM.
// Loader states, frame header default and instruction memory geometry.
package td4_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_SUM,
    S_HOLD,
    S_RUN
  } state_t;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam int         DEPTH          = 16;
  localparam logic [7:0] NOP            = 8'h00;

  // N is judged on the full byte so that e.g. 8'h21 is not mistaken for a 1.
  function automatic logic len_ok(input logic [7:0] n);
    return (n != 8'd0) && (n <= 8'(DEPTH));
  endfunction

endpackage

// File: rtl/td4_prog_loader_if.sv
// Byte stream into the program loader: valid/ready handshake, one byte per transfer.
interface td4_prog_loader_if;

  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;

  modport master (output ld_valid, output ld_data, input ld_ready);
  modport slave  (input ld_valid, input ld_data, output ld_ready);

endinterface

// File: rtl/td4_prog_ram.sv
// 16x8 instruction RAM: one synchronous write port, one asynchronous read port, no reset.
module td4_prog_ram
  import td4_pkg::*;
(
  input  logic       clock,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [7:0] wdata,
  input  logic [3:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/td4_prog_loader.sv
// Instruction memory plus framed byte-stream loader feeding the TD4 cpu fetch port.
// Frame: HEADER, N, N payload bytes, SUM (payload mod 256); cpu held in reset until a good load.
module td4_prog_loader
  import td4_pkg::*;
#(
  parameter logic [7:0] HEADER   = HEADER_DEFAULT,
  parameter int         HOLD_CYC = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [3:0]          address,
  output logic [7:0]          data,
  td4_prog_loader_if.slave    ld,
  output logic                cpu_reset,
  output logic                loaded,
  output logic                load_err
);

  state_t     state;
  logic [4:0] len;
  logic [4:0] n_len;
  logic [4:0] idx;
  logic [7:0] acc;
  logic [3:0] cnt;
  logic       accept;
  logic       ram_we;
  logic [7:0] ram_rdata;

  assign ld.ld_ready = (state != S_HOLD);
  assign accept      = ld.ld_valid && ld.ld_ready;
  assign ram_we      = accept && (state == S_DATA);

  td4_prog_ram u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (idx[3:0]),
    .wdata (ld.ld_data),
    .raddr (address),
    .rdata (ram_rdata)
  );

  // len stays 0 until a frame verifies, so a half-written RAM is never visible.
  assign data = ({1'b0, address} < len) ? ram_rdata : NOP;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      len       <= '0;
      n_len     <= '0;
      idx       <= '0;
      acc       <= '0;
      cnt       <= '0;
      cpu_reset <= 1'b1;
      loaded    <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && ld.ld_data == HEADER) begin
            state    <= S_LEN;
            load_err <= 1'b0;
          end
        end
        S_LEN: begin
          if (accept) begin
            if (len_ok(ld.ld_data)) begin
              state <= S_DATA;
              n_len <= ld.ld_data[4:0];
              idx   <= '0;
              acc   <= '0;
            end else begin
              state    <= S_IDLE;
              load_err <= 1'b1;
              len      <= '0;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            acc <= acc + ld.ld_data;
            idx <= idx + 5'd1;
            if (idx + 5'd1 == n_len) begin
              state <= S_SUM;
            end
          end
        end
        S_SUM: begin
          if (accept) begin
            if (ld.ld_data == acc) begin
              state <= S_HOLD;
              len   <= n_len;
              cnt   <= 4'(HOLD_CYC);
            end else begin
              state    <= S_IDLE;
              load_err <= 1'b1;
              len      <= '0;
            end
          end
        end
        // Release happens on the edge where the countdown reaches zero.
        S_HOLD: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state     <= S_RUN;
            cpu_reset <= 1'b0;
            loaded    <= 1'b1;
          end
        end
        S_RUN: begin
          if (accept && ld.ld_data == HEADER) begin
            state     <= S_LEN;
            cpu_reset <= 1'b1;
            loaded    <= 1'b0;
            len       <= '0;
            load_err  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_td4_prog_loader.sv
// Self-checking bench for td4_prog_loader: vector table, hand-written corner sequences,
// then randomized framed traffic against a frame-level reference model.
module tb_td4_prog_loader;

  localparam int HOLD = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] address;
  logic [7:0] data;
  logic       cpu_reset;
  logic       loaded;
  logic       load_err;

  td4_prog_loader_if ld ();

  td4_prog_loader #(.HEADER(8'hA5), .HOLD_CYC(HOLD)) dut (
    .clock     (clock),
    .reset     (reset),
    .address   (address),
    .data      (data),
    .ld        (ld),
    .cpu_reset (cpu_reset),
    .loaded    (loaded),
    .load_err  (load_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [159:0] bytes;
    int           n;
    logic         exp_err;
    logic         exp_loaded;
    logic [7:0]   exp_d0;
    logic [7:0]   exp_d1;
    logic [7:0]   exp_d2;
  } vec_t;

  vec_t tbl [6];

  // Frame-level reference model state
  logic [7:0] m_mem [16];
  int         m_len;
  bit         m_err;
  bit         m_run;
  bit         m_in_frame;
  int         m_hold;
  logic [7:0] m_buf [$];
  logic [7:0] stream [$];

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset       = 1'b1;
    ld.ld_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    int waited = 0;
    ld.ld_valid = 1'b1;
    ld.ld_data  = b;
    while (ld.ld_ready !== 1'b1 && waited < 64) begin
      tick();
      waited++;
    end
    if (waited >= 64) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout actual=0 expected=1");
    end
    tick();
    ld.ld_valid = 1'b0;
  endtask

  function automatic logic [7:0] vecByte(input logic [159:0] v, input int n, input int i);
    return v[(n - 1 - i) * 8 +: 8];
  endfunction

  task automatic sendVec(input logic [159:0] v, input int n);
    for (int i = 0; i < n; i++) applyStimulus(vecByte(v, n, i));
  endtask

  task automatic checkData(input string name, input int a, input logic [7:0] expected);
    address = 4'(a);
    #1;
    checkOutput($sformatf("%s_data%0d", name, a), data, expected);
  endtask

  function automatic void modelReset();
    m_len      = 0;
    m_err      = 1'b0;
    m_run      = 1'b0;
    m_in_frame = 1'b0;
    m_hold     = 0;
    m_buf.delete();
  endfunction

  function automatic void modelByte(input logic [7:0] b);
    int n;
    int sum;
    if (!m_in_frame) begin
      if (b == 8'hA5) begin
        m_in_frame = 1'b1;
        m_buf.delete();
        m_len = 0;
        m_err = 1'b0;
        m_run = 1'b0;
      end
    end else begin
      m_buf.push_back(b);
      n = int'(m_buf[0]);
      if (m_buf.size() == 1) begin
        if (n == 0 || n > 16) begin
          m_in_frame = 1'b0;
          m_err      = 1'b1;
        end
      end else if (m_buf.size() == n + 2) begin
        sum = 0;
        for (int i = 1; i <= n; i++) sum += int'(m_buf[i]);
        if ((sum % 256) == int'(m_buf[n + 1])) begin
          for (int i = 0; i < n; i++) m_mem[i] = m_buf[i + 1];
          m_len  = n;
          m_hold = HOLD;
        end else begin
          m_err = 1'b1;
        end
        m_in_frame = 1'b0;
      end
    end
  endfunction

  function automatic void genFrame();
    int         kind;
    int         n;
    int         sum;
    logic [7:0] b;
    logic [7:0] s;
    kind = int'($urandom_range(0, 99));
    if (kind < 15) begin
      stream.push_back(8'($urandom_range(0, 255)));
    end else if (kind < 25) begin
      stream.push_back(8'hA5);
      n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(17, 255));
      stream.push_back(8'(n));
    end else begin
      n = int'($urandom_range(1, 16));
      stream.push_back(8'hA5);
      stream.push_back(8'(n));
      sum = 0;
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom_range(0, 255));
        stream.push_back(b);
        sum += int'(b);
      end
      s = sum[7:0];
      if (kind < 40) s = s ^ 8'($urandom_range(1, 255));
      stream.push_back(s);
    end
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit         do_rst;
    bit         acc;
    logic [7:0] exp_data;

    reset       = 1'b1;
    ld.ld_valid = 1'b0;
    ld.ld_data  = 8'h00;
    address     = 4'd0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    checkOutput("rst_cpu_reset", cpu_reset, 1);
    checkOutput("rst_loaded", loaded, 0);
    checkOutput("rst_load_err", load_err, 0);
    checkOutput("rst_ld_ready", ld.ld_ready, 1);
    for (int a = 0; a < 16; a++) checkData("rst", a, 8'h00);

    // Vector table
    tbl[0] = '{bytes: 160'({8'hA5, 8'h02, 8'h3F, 8'hB3, 8'hF2}), n: 5,
               exp_err: 1'b0, exp_loaded: 1'b1, exp_d0: 8'h3F, exp_d1: 8'hB3, exp_d2: 8'h00};
    tbl[1] = '{bytes: 160'({8'hA5, 8'h01, 8'hB7, 8'h00}), n: 4,
               exp_err: 1'b1, exp_loaded: 1'b0, exp_d0: 8'h00, exp_d1: 8'h00, exp_d2: 8'h00};
    tbl[2] = '{bytes: 160'({8'hA5, 8'h00}), n: 2,
               exp_err: 1'b1, exp_loaded: 1'b0, exp_d0: 8'h00, exp_d1: 8'h00, exp_d2: 8'h00};
    tbl[3] = '{bytes: 160'({8'hA5, 8'h11}), n: 2,
               exp_err: 1'b1, exp_loaded: 1'b0, exp_d0: 8'h00, exp_d1: 8'h00, exp_d2: 8'h00};
    tbl[4] = '{bytes: 160'({8'h12, 8'h34, 8'hA5, 8'h01, 8'hA5, 8'hA5}), n: 6,
               exp_err: 1'b0, exp_loaded: 1'b1, exp_d0: 8'hA5, exp_d1: 8'h00, exp_d2: 8'h00};
    tbl[5] = '{bytes: 160'({8'hA5, 8'h10}), n: 19,
               exp_err: 1'b0, exp_loaded: 1'b1, exp_d0: 8'h00, exp_d1: 8'h11, exp_d2: 8'h22};
    for (int i = 0; i < 16; i++) tbl[5].bytes = {tbl[5].bytes[151:0], 8'(i * 17)};
    tbl[5].bytes = {tbl[5].bytes[151:0], 8'hF8};

    for (int v = 0; v < 6; v++) begin
      doReset();
      sendVec(tbl[v].bytes, tbl[v].n);
      repeat (HOLD + 2) tick();
      checkOutput($sformatf("vec%0d_load_err", v), load_err, tbl[v].exp_err);
      checkOutput($sformatf("vec%0d_loaded", v), loaded, tbl[v].exp_loaded);
      checkOutput($sformatf("vec%0d_cpu_reset", v), cpu_reset, !tbl[v].exp_loaded);
      checkData($sformatf("vec%0d", v), 0, tbl[v].exp_d0);
      checkData($sformatf("vec%0d", v), 1, tbl[v].exp_d1);
      checkData($sformatf("vec%0d", v), 2, tbl[v].exp_d2);
    end

    // Release timing, HOLD backpressure and reload from RUN
    doReset();
    sendVec(160'({8'hA5, 8'h02, 8'h3F, 8'hB3}), 4);
    ld.ld_valid = 1'b1;
    ld.ld_data  = 8'hF2;
    tick();
    ld.ld_data = 8'hA5;
    checkOutput("hold0_ld_ready", ld.ld_ready, 0);
    checkOutput("hold0_cpu_reset", cpu_reset, 1);
    for (int k = 1; k < HOLD; k++) begin
      tick();
      checkOutput($sformatf("hold%0d_ld_ready", k), ld.ld_ready, 0);
      checkOutput($sformatf("hold%0d_cpu_reset", k), cpu_reset, 1);
    end
    tick();
    checkOutput("run_cpu_reset", cpu_reset, 0);
    checkOutput("run_loaded", loaded, 1);
    checkOutput("run_ld_ready", ld.ld_ready, 1);
    checkData("run", 0, 8'h3F);
    tick();
    ld.ld_valid = 1'b0;
    checkOutput("reload_cpu_reset", cpu_reset, 1);
    checkOutput("reload_loaded", loaded, 0);
    checkData("reload", 0, 8'h00);
    sendVec(160'({8'h01, 8'h7E, 8'h7E}), 3);
    repeat (HOLD + 1) tick();
    checkOutput("reload2_loaded", loaded, 1);
    checkData("reload2", 0, 8'h7E);
    checkData("reload2", 1, 8'h00);

    // Bad checksum, then the next header clears the error
    doReset();
    sendVec(160'({8'hA5, 8'h01, 8'hB7, 8'h00}), 4);
    tick();
    checkOutput("badsum_load_err", load_err, 1);
    checkOutput("badsum_cpu_reset", cpu_reset, 1);
    checkData("badsum", 0, 8'h00);
    applyStimulus(8'hA5);
    checkOutput("badsum_clear_load_err", load_err, 0);

    // Reset in the middle of a payload, then a full 16-byte frame
    doReset();
    sendVec(160'({8'hA5, 8'h01, 8'h55, 8'h55}), 4);
    repeat (HOLD + 1) tick();
    checkOutput("pre_mid_loaded", loaded, 1);
    sendVec(160'({8'hA5, 8'h05, 8'h01, 8'h02, 8'h03}), 5);
    doReset();
    checkOutput("mid_cpu_reset", cpu_reset, 1);
    checkOutput("mid_loaded", loaded, 0);
    checkOutput("mid_ld_ready", ld.ld_ready, 1);
    for (int a = 0; a < 16; a++) checkData("mid", a, 8'h00);
    sendVec(tbl[5].bytes, tbl[5].n);
    repeat (HOLD + 1) tick();
    checkOutput("full_loaded", loaded, 1);
    checkOutput("full_cpu_reset", cpu_reset, 0);
    for (int a = 0; a < 16; a++) checkData("full", a, 8'(a * 17));

    // Randomized traffic against the reference model
    doReset();
    modelReset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (stream.size() == 0) genFrame();
      do_rst      = ($urandom_range(0, 399) == 0);
      reset       = do_rst;
      ld.ld_valid = ($urandom_range(0, 3) != 0);
      ld.ld_data  = ld.ld_valid ? stream[0] : 8'($urandom_range(0, 255));
      address     = 4'($urandom_range(0, 15));
      #1;
      exp_data = (int'(address) < m_len) ? m_mem[address] : 8'h00;
      checkOutput("rnd_ld_ready", ld.ld_ready, (m_hold == 0));
      checkOutput("rnd_cpu_reset", cpu_reset, !m_run);
      checkOutput("rnd_loaded", loaded, m_run);
      checkOutput("rnd_load_err", load_err, m_err);
      checkOutput("rnd_data", data, exp_data);
      acc = ld.ld_valid && (m_hold == 0);
      tick();
      if (do_rst) begin
        modelReset();
        stream.delete();
      end else if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) m_run = 1'b1;
      end else if (acc) begin
        modelByte(stream[0]);
        void'(stream.pop_front());
      end
    end
    reset       = 1'b0;
    ld.ld_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
